alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 Parameter OPW, default 6, opcode width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 op  input  OPW  opcode.
REQ-008 rs, rt, imm  input  WIDTH each  two's-complement operands.
REQ-009 pc_in, br_off  input  WIDTH each  current PC, branch offset.
REQ-010 out_valid  output  1  result held on outputs.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 rd, A, pc_out  output  WIDTH each  ALU result, memory address, next PC.
REQ-013 rd_we, br_taken, ovf, illegal  output  1 each  result-write, branch taken, signed overflow, unknown opcode.

Function
REQ-014 Accept occurs when in_valid && in_ready; operands are captured at accept and input changes after accept have no effect.
REQ-015 in_ready SHALL be 1 only when no multiply is in progress and (out_valid==0 or out_ready==1).
REQ-016 Opcodes: 0 ADD, 1 ADDI, 2 SUB, 3 SUBI, 4 MUL, 5 MULI, 6 OR, 7 ORI, 8 AND, 9 ANDI, 10 XOR, 11 XORI, 12 LDW, 13 STW, 14 BZ, 15 BEQ, 16 JR; all others illegal.
REQ-017 Arithmetic is plain two's complement modulo 2^WIDTH: SUB = rs - rt, SUBI = rs - imm; MUL keeps low WIDTH bits of signed product.
REQ-018 ovf=1 for ADD/ADDI/SUB/SUBI when signed result overflows; for MUL/MULI when the full signed product does not fit in WIDTH bits; else 0.
REQ-019 rd_we=1 for opcodes 0..11; 0 otherwise; rd is 0 when rd_we=0.
REQ-020 LDW/STW: A = rs + imm; A is 0 for all other opcodes.
REQ-021 BZ: br_taken = (rs==0); BEQ: br_taken = (rs==rt); taken -> pc_out = pc_in + br_off, else pc_out = pc_in.
REQ-022 JR: br_taken=1, pc_out = rs; non-branch opcodes: br_taken=0, pc_out = pc_in.
REQ-023 Illegal opcode: illegal=1, all other result outputs 0, still produces one output beat.
REQ-024 Non-multiply latency: out_valid rises the cycle after accept.
REQ-025 Multiply is iterative radix-2 shift-add: FSM IDLE -> MUL (WIDTH cycles, counter WIDTH-1 down to 0) -> DONE; out_valid rises exactly WIDTH+1 cycles after accept.
REQ-026 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-027 out_valid && out_ready with a simultaneous accept SHALL replace the result with no bubble (full throughput for non-multiply ops).
REQ-028 out_valid && out_ready without accept SHALL clear out_valid next cycle.

Reset
REQ-029 rst has priority over every other input, including an in-flight multiply, which is discarded.
REQ-030 After reset: out_valid=0, in_ready=1, rd=A=pc_out=0, rd_we=br_taken=ovf=illegal=0, FSM=IDLE, counter=0.
REQ-031 An accept attempted in the cycle rst is high SHALL be ignored.

Configuration
REQ-032 Macro ALU_PIPE_MUL_EN: when defined, MUL/MULI execute per REQ-025.
REQ-033 When ALU_PIPE_MUL_EN is undefined, the multiplier and MUL FSM states are absent; MUL/MULI are treated as illegal per REQ-023 with 1-cycle latency.

Verification
REQ-034 WIDTH=32: ADD rs=0x7FFFFFFF, rt=1 -> rd=0x80000000, ovf=1, rd_we=1, one cycle later.
REQ-035 SUBI rs=5, imm=0xFFFFFFFD (-3) -> rd=8, ovf=0; BEQ rs=rt=9, pc_in=0x100, br_off=0x20 -> pc_out=0x120, br_taken=1.
REQ-036 MUL_EN defined: MUL rs=-7, rt=6 -> rd=0xFFFFFFD6 (-42) at cycle 33 after accept, in_ready=0 cycles 1..32; undefined: illegal=1 at cycle 1.
REQ-037 out_ready held 0 for 5 cycles after result of XOR 0xF0^0x0F -> rd=0xFF stable, in_ready=0; back-to-back ops with out_ready=1 -> one result per cycle.
REQ-038 rst asserted mid-multiply (cycle 10) -> next cycle out_valid=0, in_ready=1, all outputs 0; op=0x3F -> illegal=1, rd=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Operation-in / result-out handshake bundle for alu_pipe.
//                master = producer of operations / consumer of results,
//                slave  = the ALU pipeline itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] br_off;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] pc_out;
    logic             rd_we;
    logic             br_taken;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, op, rs, rt, imm, pc_in, br_off, out_ready,
        input  in_ready, out_valid, rd, A, pc_out, rd_we, br_taken, ovf, illegal
    );

    modport slave (
        input  in_valid, op, rs, rt, imm, pc_in, br_off, out_ready,
        output in_ready, out_valid, rd, A, pc_out, rd_we, br_taken, ovf, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Single-issue ALU / branch unit with a registered result
//                stage and valid/ready handshakes. Non-multiply operations
//                complete in one cycle; MUL/MULI use an iterative radix-2
//                shift-add multiplier taking WIDTH+1 cycles.
//                Optional feature macro: ALU_PIPE_MUL_EN (multiplier present).
//                Without it MUL/MULI are reported as illegal opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);

    localparam logic [OPW-1:0] c_OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] c_OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] c_OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] c_OP_SUBI = OPW'(3);
    localparam logic [OPW-1:0] c_OP_MUL  = OPW'(4);
    localparam logic [OPW-1:0] c_OP_MULI = OPW'(5);
    localparam logic [OPW-1:0] c_OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] c_OP_ORI  = OPW'(7);
    localparam logic [OPW-1:0] c_OP_AND  = OPW'(8);
    localparam logic [OPW-1:0] c_OP_ANDI = OPW'(9);
    localparam logic [OPW-1:0] c_OP_XOR  = OPW'(10);
    localparam logic [OPW-1:0] c_OP_XORI = OPW'(11);
    localparam logic [OPW-1:0] c_OP_LDW  = OPW'(12);
    localparam logic [OPW-1:0] c_OP_STW  = OPW'(13);
    localparam logic [OPW-1:0] c_OP_BZ   = OPW'(14);
    localparam logic [OPW-1:0] c_OP_BEQ  = OPW'(15);
    localparam logic [OPW-1:0] c_OP_JR   = OPW'(16);

    logic             w_accept;
    logic             w_mul_busy;
    logic             w_is_mul;

    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_pc;
    logic             w_rd_we;
    logic             w_br;
    logic             w_ovf;
    logic             w_ill;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_rd;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_pc_out;
    logic             r_rd_we;
    logic             r_br_taken;
    logic             r_ovf;
    logic             r_illegal;

    // An accept presented while rst is high never reaches any state.
    assign w_accept     = bus.in_valid && bus.in_ready && !rst;
    assign bus.in_ready = !w_mul_busy && (!r_out_valid || bus.out_ready);

    assign bus.out_valid = r_out_valid;
    assign bus.rd        = r_rd;
    assign bus.A         = r_a;
    assign bus.pc_out    = r_pc_out;
    assign bus.rd_we     = r_rd_we;
    assign bus.br_taken  = r_br_taken;
    assign bus.ovf       = r_ovf;
    assign bus.illegal   = r_illegal;

    // Single-cycle decode/execute of the operation on the input bus.
    // Odd opcodes in the arithmetic/logic range take imm as second operand.
    always_comb begin
        w_opb    = bus.op[0] ? bus.imm : bus.rt;
        w_sum    = bus.rs + w_opb;
        w_diff   = bus.rs - w_opb;
        w_rd     = '0;
        w_a      = '0;
        w_pc     = bus.pc_in;
        w_rd_we  = 1'b0;
        w_br     = 1'b0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        w_is_mul = 1'b0;
        case (bus.op)
            c_OP_ADD, c_OP_ADDI: begin
                w_rd    = w_sum;
                w_rd_we = 1'b1;
                w_ovf   = (bus.rs[WIDTH-1] == w_opb[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            c_OP_SUB, c_OP_SUBI: begin
                w_rd    = w_diff;
                w_rd_we = 1'b1;
                w_ovf   = (bus.rs[WIDTH-1] != w_opb[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            c_OP_MUL, c_OP_MULI: begin
`ifdef ALU_PIPE_MUL_EN
                w_is_mul = 1'b1;
`else
                w_ill    = 1'b1;
                w_pc     = '0;
`endif
            end
            c_OP_OR, c_OP_ORI: begin
                w_rd    = bus.rs | w_opb;
                w_rd_we = 1'b1;
            end
            c_OP_AND, c_OP_ANDI: begin
                w_rd    = bus.rs & w_opb;
                w_rd_we = 1'b1;
            end
            c_OP_XOR, c_OP_XORI: begin
                w_rd    = bus.rs ^ w_opb;
                w_rd_we = 1'b1;
            end
            c_OP_LDW, c_OP_STW: begin
                w_a = bus.rs + bus.imm;
            end
            c_OP_BZ: begin
                w_br = (bus.rs == '0);
                if (w_br) w_pc = bus.pc_in + bus.br_off;
            end
            c_OP_BEQ: begin
                w_br = (bus.rs == bus.rt);
                if (w_br) w_pc = bus.pc_in + bus.br_off;
            end
            c_OP_JR: begin
                w_br = 1'b1;
                w_pc = bus.rs;
            end
            default: begin
                w_ill = 1'b1;
                w_pc  = '0;
            end
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int         c_CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_mpc;
    logic               r_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_start;
    logic               w_mul_last;
    logic               w_mul_ovf;

    // Multiply on magnitudes, sign restored at the end; the most negative
    // operand's magnitude still fits as an unsigned WIDTH-bit value.
    assign w_abs_a     = bus.rs[WIDTH-1] ? (~bus.rs + 1'b1) : bus.rs;
    assign w_abs_b     = w_opb[WIDTH-1]  ? (~w_opb + 1'b1)  : w_opb;
    assign w_mul_start = w_accept && w_is_mul;
    assign w_mul_busy  = (r_state == c_S_MUL);
    assign w_mul_last  = (r_state == c_S_MUL) && (r_cnt == '0);
    // MSB-first shift-add: one multiplier bit per cycle, counter WIDTH-1 .. 0.
    assign w_acc_nxt   = {r_acc[2*WIDTH-2:0], 1'b0} + (r_mplier[r_cnt] ? r_mcand : '0);
    assign w_prod      = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    // Fits in WIDTH signed bits only if the top WIDTH+1 bits are a sign run.
    assign w_mul_ovf   = !((&w_prod[2*WIDTH-1:WIDTH-1]) || ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    // Multiplier FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Multiplier FSM next-state: IDLE -> MUL (WIDTH cycles) -> DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_mul_start) w_state_nxt = c_S_MUL;
            c_S_MUL:  if (r_cnt == '0) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = w_mul_start ? c_S_MUL : c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Multiplier datapath: operand capture at accept, then accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mpc    <= '0;
            r_neg    <= 1'b0;
        end else if (w_mul_start) begin
            r_cnt    <= c_CW'(WIDTH-1);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_mpc    <= bus.pc_in;
            r_neg    <= bus.rs[WIDTH-1] ^ w_opb[WIDTH-1];
        end else if (r_state == c_S_MUL) begin
            r_acc <= w_acc_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_mul_busy = 1'b0;
`endif

    // Result stage: load on accept or multiply completion, hold while stalled,
    // drop valid once the consumer has taken the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_rd        <= '0;
            r_a         <= '0;
            r_pc_out    <= '0;
            r_rd_we     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_rd        <= w_rd;
            r_a         <= w_a;
            r_pc_out    <= w_pc;
            r_rd_we     <= w_rd_we;
            r_br_taken  <= w_br;
            r_ovf       <= w_ovf;
            r_illegal   <= w_ill;
`ifdef ALU_PIPE_MUL_EN
        end else if (w_mul_last) begin
            r_out_valid <= 1'b1;
            r_rd        <= w_prod[WIDTH-1:0];
            r_a         <= '0;
            r_pc_out    <= r_mpc;
            r_rd_we     <= 1'b1;
            r_br_taken  <= 1'b0;
            r_ovf       <= w_mul_ovf;
            r_illegal   <= 1'b0;
`endif
        end else if (bus.out_ready || w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed-vector bench for alu_pipe with a result scoreboard.
//                Follows ALU_PIPE_MUL_EN for the multiply expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] pc;
        logic        we;
        logic        br;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t q[$];

    alu_pipe_if #(.WIDTH(32), .OPW(6)) bus ();

    alu_pipe #(.WIDTH(32), .OPW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] rd, input logic [31:0] a,
                                input logic [31:0] pc, input logic we,
                                input logic br, input logic ovf, input logic ill);
        exp_t e;
        e.rd = rd; e.a = a; e.pc = pc; e.we = we; e.br = br; e.ovf = ovf; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present an operation from posedge+1, hold it until accepted, then
    // return at posedge+1 after the accepting edge with in_valid still high.
    task automatic send(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] off,
                        input exp_t e, input bit push, output int waits);
        bus.in_valid = 1'b1;
        bus.op = op; bus.rs = rs; bus.rt = rt; bus.imm = imm; bus.pc_in = pc; bus.br_off = off;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready never rose for op %0d", op);
        end
        if (push) q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: every handshaken result beat pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: rd=%h ill=%b with no expectation", bus.rd, bus.illegal);
            end else begin
                e = q.pop_front();
                if (bus.rd !== e.rd || bus.A !== e.a || bus.pc_out !== e.pc ||
                    bus.rd_we !== e.we || bus.br_taken !== e.br ||
                    bus.ovf !== e.ovf || bus.illegal !== e.ill) begin
                    n_errors++;
                    $display("FAIL sb_result: got rd=%h A=%h pc=%h we=%b br=%b ovf=%b ill=%b expected rd=%h A=%h pc=%h we=%b br=%b ovf=%b ill=%b",
                             bus.rd, bus.A, bus.pc_out, bus.rd_we, bus.br_taken, bus.ovf, bus.illegal,
                             e.rd, e.a, e.pc, e.we, e.br, e.ovf, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   bad;
        logic [31:0] hold_rd;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.rs = '0; bus.rt = '0; bus.imm = '0; bus.pc_in = '0; bus.br_off = '0;
        step(3);
        rst = 1'b0;

        // Reset state.
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_rd_a_pc", bus.rd | bus.A | bus.pc_out, 32'd0);
        chk("rst_flags", {28'd0, bus.rd_we, bus.br_taken, bus.ovf, bus.illegal}, 32'd0);

        // ADD overflow, result one cycle after accept.
        send(6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h40, 32'd0,
             mk(32'h8000_0000, 32'd0, 32'h40, 1, 0, 1, 0), 1, w);
        chk("add_latency", {31'd0, bus.out_valid}, 32'd1);
        idle();
        step(1);
        chk("out_valid_clear", {31'd0, bus.out_valid}, 32'd0);

        send(6'd3, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h44, 32'd0,
             mk(32'd8, 32'd0, 32'h44, 1, 0, 0, 0), 1, w);
        send(6'd15, 32'd9, 32'd9, 32'd0, 32'h100, 32'h20,
             mk(32'd0, 32'd0, 32'h120, 0, 1, 0, 0), 1, w);
        send(6'd2, 32'h8000_0000, 32'd1, 32'd0, 32'h48, 32'd0,
             mk(32'h7FFF_FFFF, 32'd0, 32'h48, 1, 0, 1, 0), 1, w);
        send(6'd11, 32'h0000_FFFF, 32'd0, 32'h0000_00FF, 32'h4C, 32'd0,
             mk(32'h0000_FF00, 32'd0, 32'h4C, 1, 0, 0, 0), 1, w);
        idle();
        step(2);

        // Stall: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        send(6'd10, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0,
             mk(32'hFF, 32'd0, 32'd0, 1, 0, 0, 0), 1, w);
        idle();
        hold_rd = bus.rd;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.rd !== 32'hFF || bus.in_ready !== 1'b0) bad++;
            step(1);
        end
        chk("stall_first_rd", hold_rd, 32'hFF);
        chk("stall_hold_violations", bad, 32'd0);
        bus.out_ready = 1'b1;
        step(1);
        chk("stall_release_clear", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back, one accept per cycle with the consumer always ready.
        bad = 0;
        send(6'd6, 32'hF0, 32'h0F, 32'd0, 32'h300, 32'd0, mk(32'hFF, 32'd0, 32'h300, 1, 0, 0, 0), 1, w); bad += w;
        send(6'd9, 32'hFF, 32'd0, 32'h0F, 32'h300, 32'd0, mk(32'h0F, 32'd0, 32'h300, 1, 0, 0, 0), 1, w); bad += w;
        send(6'd12, 32'h1000, 32'd0, 32'h10, 32'h300, 32'd0, mk(32'd0, 32'h1010, 32'h300, 0, 0, 0, 0), 1, w); bad += w;
        send(6'd14, 32'd0, 32'd0, 32'd0, 32'h200, 32'h8, mk(32'd0, 32'd0, 32'h208, 0, 1, 0, 0), 1, w); bad += w;
        send(6'd14, 32'd3, 32'd0, 32'd0, 32'h200, 32'h8, mk(32'd0, 32'd0, 32'h200, 0, 0, 0, 0), 1, w); bad += w;
        send(6'd16, 32'h4000, 32'd0, 32'd0, 32'h200, 32'd0, mk(32'd0, 32'd0, 32'h4000, 0, 1, 0, 0), 1, w); bad += w;
        chk("b2b_stall_cycles", bad, 32'd0);
        idle();
        step(2);

        // Multiply.
`ifdef ALU_PIPE_MUL_EN
        send(6'd4, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'h600, 32'd0,
             mk(32'hFFFF_FFD6, 32'd0, 32'h600, 1, 0, 0, 0), 1, w);
        idle();
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            step(1);
        end
        chk("mul_busy_violations", bad, 32'd0);
        chk("mul_latency_33", {31'd0, bus.out_valid}, 32'd1);
        step(1);
        send(6'd5, 32'h0001_0000, 32'd0, 32'h0001_0000, 32'h604, 32'd0,
             mk(32'd0, 32'd0, 32'h604, 1, 0, 1, 0), 1, w);
        idle();
        step(40);
`else
        send(6'd4, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'h600, 32'd0,
             mk(32'd0, 32'd0, 32'd0, 0, 0, 0, 1), 1, w);
        chk("mul_illegal_latency", {31'd0, bus.out_valid}, 32'd1);
        chk("mul_illegal_flag", {31'd0, bus.illegal}, 32'd1);
        idle();
        send(6'd5, 32'h0001_0000, 32'd0, 32'h0001_0000, 32'h604, 32'd0,
             mk(32'd0, 32'd0, 32'd0, 0, 0, 0, 1), 1, w);
        idle();
        step(2);
`endif

        // Reset in cycle 10 of a multiply, with an accept attempt under reset.
`ifdef ALU_PIPE_MUL_EN
        send(6'd4, 32'd123, 32'd456, 32'd0, 32'h700, 32'd0, mk(0, 0, 0, 0, 0, 0, 0), 0, w);
`else
        send(6'd4, 32'd123, 32'd456, 32'd0, 32'h700, 32'd0, mk(0, 0, 0, 0, 0, 0, 1), 1, w);
`endif
        idle();
        step(9);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.op = 6'd0; bus.rs = 32'd1; bus.rt = 32'd1; bus.pc_in = 32'h10;
        step(1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_outputs", bus.rd | bus.A | bus.pc_out |
            {28'd0, bus.rd_we, bus.br_taken, bus.ovf, bus.illegal}, 32'd0);
        step(1);
        rst = 1'b0;
        idle();
        chk("accept_under_rst_ignored", {31'd0, bus.out_valid}, 32'd0);
        step(1);
        chk("after_rst_idle", {31'd0, bus.out_valid}, 32'd0);

        // Unknown opcode.
        send(6'h3F, 32'h55, 32'h66, 32'h77, 32'h500, 32'h4,
             mk(32'd0, 32'd0, 32'd0, 0, 0, 0, 1), 1, w);
        chk("illegal_flag", {31'd0, bus.illegal}, 32'd1);
        chk("illegal_rd", bus.rd, 32'd0);
        idle();
        step(4);

        chk("sb_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
